// File: rtl/microsequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer_pkg
// Description : Shared microinstruction field layout, MODE and COND_SEL
//               encodings for the sequencer, control unit and assembler.
// Revision    : 1.0 - initial release
// ============================================================================
package microsequencer_pkg;

  // Control-unit field positions inside Q_cu
  localparam int CR_ADDR_LSB = 22;
  localparam int MODE_LSB    = 19;
  localparam int MODE_W      = 3;
  localparam int CSEL_LSB    = 16;
  localparam int CSEL_W      = 3;
  localparam int INV_BIT     = 15;

  localparam logic [MODE_W-1:0] MD_DISPATCH  = 3'b000;
  localparam logic [MODE_W-1:0] MD_INC       = 3'b001;
  localparam logic [MODE_W-1:0] MD_JUMP      = 3'b010;
  localparam logic [MODE_W-1:0] MD_CBRANCH   = 3'b011;
  localparam logic [MODE_W-1:0] MD_CALL      = 3'b100;
  localparam logic [MODE_W-1:0] MD_RET       = 3'b101;
  localparam logic [MODE_W-1:0] MD_CDISPATCH = 3'b110;
  localparam logic [MODE_W-1:0] MD_WAIT      = 3'b111;

  localparam logic [CSEL_W-1:0] CS_TRUE  = 3'd0;
  localparam logic [CSEL_W-1:0] CS_MOC   = 3'd1;
  localparam logic [CSEL_W-1:0] CS_COND  = 3'd2;
  localparam logic [CSEL_W-1:0] CS_IR_L  = 3'd3;
  localparam logic [CSEL_W-1:0] CS_IR_U  = 3'd4;
  localparam logic [CSEL_W-1:0] CS_IR_S  = 3'd5;
  localparam logic [CSEL_W-1:0] CS_IR_I  = 3'd6;
  localparam logic [CSEL_W-1:0] CS_ALU_Z = 3'd7;

  localparam int FETCH_ADDR = 0;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/microsequencer_stack.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer_stack
// Description : Return-address LIFO for microsubroutine call/return.
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] C_FULL_CNT = PW'(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [IW-1:0] w_top_idx;

  // r_ptr counts occupied entries; the top lives one slot below it
  assign w_top_idx = r_ptr[IW-1:0] - IW'(1);
  assign top       = r_mem[w_top_idx];
  assign full      = (r_ptr == C_FULL_CNT);
  assign empty     = (r_ptr == '0);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push && !full) begin
      r_mem[r_ptr[IW-1:0]] <= din;
      r_ptr                <= r_ptr + PW'(1);
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : Next-address generator and control-register enable with a
//               microsubroutine return stack.
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int AW          = 8,
  parameter int CU_W        = 30,
  parameter int STACK_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RESET_n,
  input  logic [CU_W-1:0] Q_cu,
  input  logic [AW-1:0]   DISPATCH_ADDR,
  input  logic [6:0]      COND_IN,
  input  logic            STALL,
  output logic [AW-1:0]   STATE,
  output logic            CR_EN,
  output logic [AW-1:0]   CUR_ADDR,
  output logic            STACK_ERR
);

  seq_state_t         r_state;
  logic [AW-1:0]      r_cur_addr;
  logic               r_stack_err;

  logic [AW-1:0]      w_cr_addr;
  logic [MODE_W-1:0]  w_mode;
  logic [CSEL_W-1:0]  w_csel;
  logic               w_inv;
  logic [7:0]         w_sel;
  logic               w_cond;
  logic [AW-1:0]      w_inc;
  logic [AW-1:0]      w_next;
  logic               w_push;
  logic               w_pop;
  logic               w_err_evt;
  logic               w_en;
  logic [AW-1:0]      w_top;
  logic               w_full;
  logic               w_empty;
  logic               w_unused_bits;

  assign w_cr_addr     = Q_cu[CR_ADDR_LSB +: AW];
  assign w_mode        = Q_cu[MODE_LSB +: MODE_W];
  assign w_csel        = Q_cu[CSEL_LSB +: CSEL_W];
  assign w_inv         = Q_cu[INV_BIT];
  assign w_unused_bits = ^Q_cu[INV_BIT-1:0];

  assign w_sel  = {COND_IN, 1'b1};
  assign w_cond = w_sel[w_csel] ^ w_inv;
  assign w_inc  = r_cur_addr + AW'(1);
  assign w_en   = RESET_n & ~STALL;

  always_comb begin
    w_next    = w_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_evt = 1'b0;
    case (w_mode)
      MD_DISPATCH:  w_next = DISPATCH_ADDR;
      MD_INC:       w_next = w_inc;
      MD_JUMP:      w_next = w_cr_addr;
      MD_CBRANCH:   if (w_cond) w_next = w_cr_addr;
      MD_CALL: begin
        if (w_cond) begin
          w_next = w_cr_addr;
          if (w_full) w_err_evt = 1'b1;
          else        w_push    = 1'b1;
        end
      end
      MD_RET: begin
        if (w_empty) begin
          w_next    = AW'(FETCH_ADDR);
          w_err_evt = 1'b1;
        end else begin
          w_next = w_top;
          w_pop  = 1'b1;
        end
      end
      MD_CDISPATCH: if (w_cond) w_next = DISPATCH_ADDR;
      MD_WAIT:      if (!w_cond) w_next = r_cur_addr;
      default:      w_next = w_inc;
    endcase
    // The control register has no reset, so its contents are garbage in PRIME
    if (r_state == ST_PRIME) begin
      w_next    = AW'(FETCH_ADDR);
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_evt = 1'b0;
    end
  end

  microsequencer_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (AW)
  ) u_stack (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .push    (w_en & w_push),
    .pop     (w_en & w_pop),
    .din     (w_inc),
    .top     (w_top),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= ST_PRIME;
      r_cur_addr  <= '0;
      r_stack_err <= 1'b0;
    end else if (w_en) begin
      r_state    <= ST_RUN;
      r_cur_addr <= w_next;
      if (w_err_evt) r_stack_err <= 1'b1;
    end
  end

  assign STATE     = w_next;
  assign CR_EN     = w_en;
  assign CUR_ADDR  = r_cur_addr;
  assign STACK_ERR = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Scoreboard bench for microsequencer against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microsequencer;

  logic        CLK;
  logic        RESET_n;
  logic [29:0] Q_cu;
  logic [7:0]  DISPATCH_ADDR;
  logic [6:0]  COND_IN;
  logic        STALL;
  logic [7:0]  STATE;
  logic        CR_EN;
  logic [7:0]  CUR_ADDR;
  logic        STACK_ERR;

  microsequencer #(.AW(8), .CU_W(30), .STACK_DEPTH(4)) dut (
    .CLK           (CLK),
    .RESET_n       (RESET_n),
    .Q_cu          (Q_cu),
    .DISPATCH_ADDR (DISPATCH_ADDR),
    .COND_IN       (COND_IN),
    .STALL         (STALL),
    .STATE         (STATE),
    .CR_EN         (CR_EN),
    .CUR_ADDR      (CUR_ADDR),
    .STACK_ERR     (STACK_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] state;
    logic       cr_en;
    logic [7:0] cur;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int   m_cur;
  int   m_stk[$];
  bit   m_err;
  bit   m_prime;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [29:0] mk(input int cr, input int mode, input int csel, input int inv);
    logic [29:0] w;
    w = 30'($urandom);
    w[29:22] = 8'(cr);
    w[21:19] = 3'(mode);
    w[18:16] = 3'(csel);
    w[15]    = 1'(inv);
    return w;
  endfunction

  // Next address from the microinstruction rules; stack effects reported back
  function automatic int model_next(input logic [29:0] cu, input int disp, input logic [6:0] cin,
                                    output bit push, output bit pop, output bit seterr);
    int  cr, mode, csel, inc;
    bit  c;
    push = 0; pop = 0; seterr = 0;
    if (m_prime) return 0;
    cr   = int'(cu[29:22]);
    mode = int'(cu[21:19]);
    csel = int'(cu[18:16]);
    c    = (csel == 0) ? 1'b1 : cin[csel-1];
    c    = c ^ cu[15];
    inc  = (m_cur + 1) % 256;
    case (mode)
      0: return disp;
      1: return inc;
      2: return cr;
      3: return c ? cr : inc;
      4: begin
        if (!c) return inc;
        if (m_stk.size() < 4) push = 1; else seterr = 1;
        return cr;
      end
      5: begin
        if (m_stk.size() == 0) begin seterr = 1; return 0; end
        pop = 1;
        return m_stk[m_stk.size()-1];
      end
      6: return c ? disp : inc;
      default: return c ? inc : m_cur;
    endcase
  endfunction

  // Drive one cycle (called at posedge+1), queue the expectation, commit model after edge
  task automatic step(input logic [29:0] cu, input int disp, input logic [6:0] cin, input bit stall);
    exp_t e;
    bit   p, q, se;
    int   nxt;
    Q_cu          = cu;
    DISPATCH_ADDR = 8'(disp);
    COND_IN       = cin;
    STALL         = stall;
    nxt     = model_next(cu, disp, cin, p, q, se);
    e.state = 8'(nxt);
    e.cr_en = ~stall;
    e.cur   = 8'(m_cur);
    e.err   = m_err;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (!stall) begin
      if (p) m_stk.push_back((m_cur + 1) % 256);
      if (q) void'(m_stk.pop_back());
      if (se) m_err = 1;
      m_cur   = nxt;
      m_prime = 0;
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_stk.delete(); m_err = 0; m_prime = 1;
  endtask

  // Reset asserted mid-cycle; asynchronous clear must be visible at once
  task automatic do_reset();
    @(negedge CLK);
    #1;
    RESET_n = 1'b0;
    #1;
    check("rst_cur_addr", int'(CUR_ADDR), 0);
    check("rst_state", int'(STATE), 0);
    check("rst_cr_en", int'(CR_EN), 0);
    check("rst_stack_err", int'(STACK_ERR), 0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET_n = 1'b1;
  endtask

  // Monitor: compare every queued expectation away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("STATE", int'(STATE), int'(e.state));
        check("CR_EN", int'(CR_EN), int'(e.cr_en));
        check("CUR_ADDR", int'(CUR_ADDR), int'(e.cur));
        check("STACK_ERR", int'(STACK_ERR), int'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] cin;
    RESET_n = 1'b0; STALL = 1'b0; COND_IN = '0; DISPATCH_ADDR = 8'h5A;
    Q_cu = mk(8'hC3, 2, 0, 0);
    model_reset();
    #3;
    check("reset_state", int'(STATE), 0);
    check("reset_cr_en", int'(CR_EN), 0);
    check("reset_cur", int'(CUR_ADDR), 0);
    check("reset_err", int'(STACK_ERR), 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_n = 1'b1;

    // Sequential increment from PRIME, then wrap at 8'hFF
    step(mk(8'h77, 2, 0, 0), 0, '0, 0);
    check("first_edge_cur", int'(CUR_ADDR), 0);
    for (int i = 0; i < 5; i++) step(mk(0, 1, 0, 0), 0, '0, 0);
    check("inc_cur", int'(CUR_ADDR), 5);
    step(mk(8'hFE, 2, 0, 0), 0, '0, 0);
    step(mk(0, 1, 0, 0), 0, '0, 0);
    step(mk(0, 1, 0, 0), 0, '0, 0);
    check("wrap_cur", int'(CUR_ADDR), 0);

    // Conditional branch on ARM condition pass, both polarities
    step(mk(8'h10, 2, 0, 0), 0, '0, 0);
    step(mk(8'h40, 3, 2, 0), 0, 7'b0000010, 0);
    check("cbranch_taken", int'(CUR_ADDR), 8'h40);
    step(mk(8'h10, 2, 0, 0), 0, '0, 0);
    step(mk(8'h40, 3, 2, 1), 0, 7'b0000010, 0);
    check("cbranch_inv", int'(CUR_ADDR), 8'h11);

    // Nested call/return
    step(mk(8'h20, 2, 0, 0), 0, '0, 0);
    step(mk(8'h50, 4, 0, 0), 0, '0, 0);
    step(mk(8'h55, 2, 0, 0), 0, '0, 0);
    step(mk(8'h60, 4, 0, 0), 0, '0, 0);
    step(mk(0, 5, 0, 0), 0, '0, 0);
    check("ret1", int'(CUR_ADDR), 8'h56);
    step(mk(0, 5, 0, 0), 0, '0, 0);
    check("ret2", int'(CUR_ADDR), 8'h21);
    check("callret_err", int'(STACK_ERR), 0);

    // Overflow: fifth nested call
    for (int i = 0; i < 5; i++) step(mk(8'h80 + 8*i, 4, 0, 0), 0, '0, 0);
    check("ovf_target", int'(CUR_ADDR), 8'hA0);
    check("ovf_err", int'(STACK_ERR), 1);

    // Underflow after reset
    do_reset();
    step(mk(0, 1, 0, 0), 0, '0, 0);
    step(mk(8'h33, 5, 0, 0), 0, '0, 0);
    check("udf_cur", int'(CUR_ADDR), 0);
    check("udf_err", int'(STACK_ERR), 1);

    // Wait on MOC with a stall in the middle
    step(mk(8'h30, 2, 0, 0), 0, '0, 0);
    for (int i = 0; i < 3; i++) step(mk(0, 7, 1, 0), 0, 7'b0, 0);
    step(mk(0, 7, 1, 0), 0, 7'b0, 1);
    step(mk(0, 7, 1, 0), 0, 7'b1, 1);
    check("stall_hold", int'(CUR_ADDR), 8'h30);
    step(mk(0, 7, 1, 0), 0, 7'b1, 0);
    check("wait_release", int'(CUR_ADDR), 8'h31);

    // Dispatch then asynchronous reset mid-run
    step(mk(0, 0, 0, 0), 8'h9A, '0, 0);
    check("dispatch", int'(CUR_ADDR), 8'h9A);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cin = 7'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(mk($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1)),
                $urandom_range(0, 255), cin, ($urandom_range(0, 9) == 0));
    end

    @(posedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
